// File: rtl/uart_rx_fifo.sv
// UART receive buffer: frame handshake FSM feeding a circular FIFO popped by read_nic.
// Define UART_RX_FIFO_OVERWRITE_EN to keep the newest bytes (discard oldest) on overflow.
module uart_rx_fifo #(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [WORD_SIZE-1:0]  rx_data,
  output logic                  rx_ack,
  input  logic                  read_nic,
  output logic [WORD_SIZE-1:0]  data_out,
  output logic                  read_nic_i,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int unsigned          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACK      = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  logic [WORD_SIZE-1:0]  mem_q [DEPTH];
  logic [1:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [WORD_SIZE-1:0]  data_q, data_d;
  logic                  ack_q;
  logic                  rdy_q;
  logic                  ovf_q, ovf_d;

  logic push_req, pop_do, full, drop, push_do, discard;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rx_valid) state_d = ACK;
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!rx_valid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign push_req = (state_q == IDLE) && rx_valid;
  assign pop_do   = read_nic && (count_q != '0);
  assign full     = (count_q == FULL_CNT);
  assign drop     = push_req && full && !pop_do;

`ifdef UART_RX_FIFO_OVERWRITE_EN
  // Full without a pop: evict the oldest word so the newest one fits.
  assign push_do = push_req;
  assign discard = drop;
`else
  assign push_do = push_req && !drop;
  assign discard = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_do) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_do || discard) rd_ptr_d = rd_ptr_q + 1'b1;
    if (pop_do) data_d = mem_q[rd_ptr_q];
    if (push_do && !pop_do && !discard) count_d = count_q + 1'b1;
    else if (pop_do && !push_do)        count_d = count_q - 1'b1;
    if (clear_overflow) ovf_d = 1'b0;
    if (drop)           ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      ack_q    <= 1'b0;
      rdy_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      ack_q    <= (state_d == ACK);
      rdy_q    <= (count_d != '0);
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push_do) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rx_ack     = ack_q;
  assign data_out   = data_q;
  assign read_nic_i = rdy_q;
  assign count      = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: handshake, ordering, full/overflow, simultaneous events, reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ack;
  logic       read_nic;
  logic [7:0] data_out;
  logic       read_nic_i;
  logic [4:0] count;
  logic       overflow;
  logic       clear_overflow;

  int errors = 0;
  int checks = 0;
  int acks   = 0;
  int ack0;

`ifdef UART_RX_FIFO_OVERWRITE_EN
  localparam int OW = 1;
`else
  localparam int OW = 0;
`endif

  uart_rx_fifo #(.WORD_SIZE(8), .DEPTH_LOG2(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ack         (rx_ack),
    .read_nic       (read_nic),
    .data_out       (data_out),
    .read_nic_i     (read_nic_i),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  initial forever #10 clk = ~clk;

  // All driving and sampling happens at the falling edge.
  task automatic step();
    @(negedge clk);
    if (rx_ack === 1'b1) acks++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_valid = 1'b1;
    rx_data  = b;
    repeat (hold) step();
    rx_valid = 1'b0;
    step();
    step();
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp_d, input logic [4:0] exp_c);
    read_nic = 1'b1;
    step();
    read_nic = 1'b0;
    chk(tag, 32'(data_out), 32'(exp_d));
    chk({tag, "_cnt"}, 32'(count), 32'(exp_c));
  endtask

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_data = '0; read_nic = 1'b0; clear_overflow = 1'b0;
    step(); step();
    chk("rst_count", 32'(count), 0);
    chk("rst_rdy", 32'(read_nic_i), 0);
    chk("rst_ack", 32'(rx_ack), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b1;
    step();

    // Single frame with rx_valid held 3 cycles
    ack0 = acks;
    rx_valid = 1'b1; rx_data = 8'h55;
    chk("pre_rdy", 32'(read_nic_i), 0);
    step();
    chk("frame_cnt", 32'(count), 1);
    chk("frame_rdy", 32'(read_nic_i), 1);
    chk("frame_ack", 32'(rx_ack), 1);
    step();
    chk("frame_ack_low", 32'(rx_ack), 0);
    step();
    rx_valid = 1'b0;
    step(); step(); step();
    chk("frame_acks", 32'(acks - ack0), 1);
    chk("frame_cnt2", 32'(count), 1);
    pop_chk("pop55", 8'h55, 5'd0);
    chk("pop55_rdy", 32'(read_nic_i), 0);

    // Ordering
    send_byte(8'h55, 1);
    send_byte(8'hAA, 1);
    send_byte(8'h0F, 1);
    chk("ord_cnt", 32'(count), 3);
    pop_chk("ord0", 8'h55, 5'd2); step(); step();
    pop_chk("ord1", 8'hAA, 5'd1); step(); step();
    pop_chk("ord2", 8'h0F, 5'd0); step(); step();

    // Full / overflow with 17 pushes
    ack0 = acks;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1);
    chk("full16_ovf", 32'(overflow), 0);
    send_byte(8'h10, 1);
    chk("full_acks", 32'(acks - ack0), 17);
    chk("full_cnt", 32'(count), 16);
    chk("full_ovf", 32'(overflow), 1);
    for (int i = 0; i < 16; i++) pop_chk("drain", 8'(i + OW), 5'(15 - i));
    chk("drain_rdy", 32'(read_nic_i), 0);
    chk("drain_ovf", 32'(overflow), 1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);

    // Full with simultaneous push+pop
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1);
    chk("sim_full", 32'(count), 16);
    rx_valid = 1'b1; rx_data = 8'hC3; read_nic = 1'b1;
    step();
    rx_valid = 1'b0; read_nic = 1'b0;
    chk("sim_data", 32'(data_out), 32'h20);
    chk("sim_cnt", 32'(count), 16);
    step(); step();
    chk("sim_ovf", 32'(overflow), 0);
    for (int i = 1; i < 16; i++) pop_chk("sim_drain", 8'(8'h20 + i), 5'(16 - i));
    pop_chk("sim_last", 8'hC3, 5'd0);

    // Pop while empty is ignored
    pop_chk("empty_pop", 8'hC3, 5'd0);

    // Empty with simultaneous push+pop: push only
    rx_valid = 1'b1; rx_data = 8'h7E; read_nic = 1'b1;
    step();
    rx_valid = 1'b0; read_nic = 1'b0;
    chk("emp_sim_data", 32'(data_out), 32'hC3);
    chk("emp_sim_cnt", 32'(count), 1);
    step(); step();
    pop_chk("emp_sim_pop", 8'h7E, 5'd0);

    // Reset with 5 stored words and FSM in WAIT_LOW
    for (int i = 0; i < 4; i++) send_byte(8'(8'h90 + i), 1);
    rx_valid = 1'b1; rx_data = 8'h99;
    step(); step();
    chk("mid_cnt", 32'(count), 5);
    rst = 1'b0;
    step();
    rst = 1'b1; rx_valid = 1'b0;
    chk("mrst_cnt", 32'(count), 0);
    chk("mrst_rdy", 32'(read_nic_i), 0);
    chk("mrst_data", 32'(data_out), 0);
    chk("mrst_ack", 32'(rx_ack), 0);
    step();
    ack0 = acks;
    send_byte(8'h3C, 1);
    chk("post_acks", 32'(acks - ack0), 1);
    chk("post_cnt", 32'(count), 1);
    pop_chk("post_pop", 8'h3C, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
